// File: rtl/clk_div_pkg.sv
// Shared types, default constants and ratio legality check for the clock-divider
// configuration controller.
package clk_div_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD, SETTLE} cfg_state_e;

  localparam int          RATIO_WD_DEF    = 8;
  localparam logic [7:0]  MAX_RATIO_DEF   = 8'd128;
  localparam logic [7:0]  RESET_RATIO_DEF = 8'd1;
  localparam int unsigned QUIET_CYC_DEF   = 4;
  localparam int unsigned SETTLE_CYC_DEF  = 2;
  localparam int          TMR_WD          = 4;

  // Ratio 0 would stall the divider; 1 is bypass and therefore legal.
  function automatic logic is_legal_ratio(input logic [15:0] ratio,
                                          input logic [15:0] max_ratio);
    return (ratio != 16'd0) && (ratio <= max_ratio);
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// Load/down-count timer; o_expire is high in the last counted cycle of a
// state that loaded it on entry.
module cyc_timer
  import clk_div_pkg::*;
(
  input  logic              i_ref_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [TMR_WD-1:0] i_load_val,
  output logic              o_expire
);

  logic [TMR_WD-1:0] cnt;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= i_load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_WD'(1);
    end
  end

  assign o_expire = (cnt == TMR_WD'(1));

endmodule

// File: rtl/clk_div_cfg.sv
// Ratio-update controller for CLK_DIV: validates requests and applies them
// through drain / load / settle so the ratio never changes while enabled.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int                    RATIO_WD    = RATIO_WD_DEF,
  parameter logic [RATIO_WD-1:0]   MAX_RATIO   = RATIO_WD'(MAX_RATIO_DEF),
  parameter logic [RATIO_WD-1:0]   RESET_RATIO = RATIO_WD'(RESET_RATIO_DEF),
  parameter int unsigned           QUIET_CYC   = QUIET_CYC_DEF,
  parameter int unsigned           SETTLE_CYC  = SETTLE_CYC_DEF
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_cfg_valid,
  input  logic [RATIO_WD-1:0] i_cfg_ratio,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_clk_en,
  output logic                o_busy,
  output logic                o_cfg_done,
  output logic                o_cfg_err
);

  cfg_state_e          state_q, state_d;
  logic [RATIO_WD-1:0] target_q, target_d;
  logic [RATIO_WD-1:0] pend_q, pend_d;
  logic [RATIO_WD-1:0] ratio_d;
  logic                pend_vld_q, pend_vld_d;
  logic                clk_en_d, busy_d, done_d, err_d;
  logic                err_owed_q, err_owed_d, err_any;
  logic                legal, legal_req, bad_req;
  logic                tmr_load, tmr_expire;
  logic [TMR_WD-1:0]   tmr_val;

  assign legal     = is_legal_ratio(16'(i_cfg_ratio), 16'(MAX_RATIO));
  assign legal_req = i_cfg_valid & legal;
  assign bad_req   = i_cfg_valid & ~legal;

  cyc_timer u_timer (
    .i_ref_clk  (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_expire   (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ratio_d    = o_div_ratio;
    clk_en_d   = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = TMR_WD'(QUIET_CYC);

    // Any legal request seen while busy lands in the one-deep pending slot.
    if (state_q != RUN && legal_req) begin
      pend_d     = i_cfg_ratio;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        clk_en_d = i_enable;
        busy_d   = 1'b0;
        if (legal_req) begin
          if (i_cfg_ratio == o_div_ratio) begin
            done_d = 1'b1;
          end else begin
            target_d = i_cfg_ratio;
            state_d  = DRAIN;
            clk_en_d = 1'b0;
            busy_d   = 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (tmr_expire) state_d = LOAD;
      end
      LOAD: begin
        ratio_d  = target_q;
        state_d  = SETTLE;
        tmr_load = 1'b1;
        tmr_val  = TMR_WD'(SETTLE_CYC);
      end
      SETTLE: begin
        if (tmr_expire) begin
          done_d = 1'b1;
          // Enable is already low, so a queued ratio goes straight to LOAD.
          if (legal_req || pend_vld_q) begin
            target_d   = legal_req ? i_cfg_ratio : pend_q;
            pend_vld_d = 1'b0;
            state_d    = LOAD;
          end else begin
            state_d  = RUN;
            busy_d   = 1'b0;
            clk_en_d = i_enable;
          end
        end
      end
      default: state_d = RUN;
    endcase

    // A reject that coincides with a done pulse is reported one cycle later.
    err_any = bad_req | err_owed_q;
    if (done_d) begin
      err_d      = 1'b0;
      err_owed_d = err_any;
    end else begin
      err_d      = err_any;
      err_owed_d = 1'b0;
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      pend_vld_q  <= 1'b0;
      err_owed_q  <= 1'b0;
      o_div_ratio <= RESET_RATIO;
      o_clk_en    <= 1'b0;
      o_busy      <= 1'b0;
      o_cfg_done  <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      err_owed_q  <= err_owed_d;
      o_div_ratio <= ratio_d;
      o_clk_en    <= clk_en_d;
      o_busy      <= busy_d;
      o_cfg_done  <= done_d;
      o_cfg_err   <= err_d;
    end
  end

  // Ratio holding registers are qualified by state/pend_vld_q and need no reset.
  always_ff @(posedge i_ref_clk) begin
    target_q <= target_d;
    pend_q   <= pend_d;
  end

endmodule
